// File: rtl/internoc_ni_txn_scheduler.sv
// Round-robin scheduler sharing one InterNoC NI AXI master port between NUM_REQ requesters.
// Issues a one-cycle INIT pulse, waits for the master's DONE rising edge under a watchdog.
module internoc_ni_txn_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    output logic [NUM_REQ-1:0]        REQ_GNT,
    output logic [NUM_REQ-1:0]        REQ_DONE,
    output logic [NUM_REQ-1:0]        REQ_ERR,
    output logic                      REQ_TIMEOUT,
    output logic                      M_AXI_INIT_AXI_TXN,
    output logic [ADDR_W-1:0]         M_AXI_TARGET_BASE,
    input  logic                      M_AXI_TXN_DONE,
    input  logic                      M_AXI_ERROR,
    output logic                      BUSY,
    output logic [15:0]               TXN_COUNT
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT,
        RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic [WD_W-1:0]    wd_q;
    logic               done_q;
    logic               completion;
    logic               wd_expired;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;

    // Search starts just after the last grant and wraps, so the first hit is the winner.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(last_q) + 32'd1 + i) % NUM_REQ);
            if (!win_valid && REQ[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        completion = M_AXI_TXN_DONE & ~done_q;
        wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
        case (state_q)
            IDLE:    if (win_valid) state_d = PULSE;
            PULSE:   state_d = WAIT;
            WAIT:    if (completion || wd_expired) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign BUSY = (state_q != IDLE);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q            <= IDLE;
            last_q             <= IDX_W'(NUM_REQ - 1);
            gnt_idx_q          <= '0;
            wd_q               <= '0;
            done_q             <= 1'b0;
            REQ_GNT            <= '0;
            REQ_DONE           <= '0;
            REQ_ERR            <= '0;
            REQ_TIMEOUT        <= 1'b0;
            M_AXI_INIT_AXI_TXN <= 1'b0;
            M_AXI_TARGET_BASE  <= '0;
            TXN_COUNT          <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= M_AXI_TXN_DONE;
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        REQ_GNT            <= NUM_REQ'(1) << win_idx;
                        gnt_idx_q          <= win_idx;
                        M_AXI_TARGET_BASE  <= REQ_ADDR[32'(win_idx) * ADDR_W +: ADDR_W];
                        M_AXI_INIT_AXI_TXN <= 1'b1;
                    end
                end
                PULSE: begin
                    M_AXI_INIT_AXI_TXN <= 1'b0;
                    wd_q               <= '0;
                end
                WAIT: begin
                    // A genuine completion takes precedence over a coincident watchdog expiry.
                    if (completion) begin
                        REQ_DONE    <= REQ_GNT;
                        REQ_ERR     <= M_AXI_ERROR ? REQ_GNT : '0;
                        REQ_TIMEOUT <= 1'b0;
                        REQ_GNT     <= '0;
                    end else if (wd_expired) begin
                        REQ_DONE    <= REQ_GNT;
                        REQ_ERR     <= REQ_GNT;
                        REQ_TIMEOUT <= 1'b1;
                        REQ_GNT     <= '0;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                RESP: begin
                    REQ_DONE    <= '0;
                    REQ_ERR     <= '0;
                    REQ_TIMEOUT <= 1'b0;
                    TXN_COUNT   <= TXN_COUNT + 16'd1;
                    last_q      <= gnt_idx_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_internoc_ni_txn_scheduler.sv
// Directed bench for internoc_ni_txn_scheduler: main DUT with default watchdog, second DUT with a 16-cycle watchdog.
module tb_internoc_ni_txn_scheduler;

    logic         tb_ACLK;
    logic         areset;
    logic [3:0]   req;
    logic [127:0] req_addr;
    logic [3:0]   gnt, rdone, rerr;
    logic         rto, init, done, error, busy;
    logic [31:0]  base;
    logic [15:0]  cnt;

    logic         wd_areset;
    logic [3:0]   wd_req;
    logic [3:0]   wd_gnt, wd_rdone, wd_rerr;
    logic         wd_rto, wd_init, wd_done, wd_error, wd_busy;
    logic [31:0]  wd_base;
    logic [15:0]  wd_cnt;

    int checks = 0;
    int fails  = 0;

    internoc_ni_txn_scheduler #(.NUM_REQ(4), .ADDR_W(32), .TIMEOUT_CYCLES(4096)) dut (
        .ACLK(tb_ACLK), .ARESET(areset), .REQ(req), .REQ_ADDR(req_addr),
        .REQ_GNT(gnt), .REQ_DONE(rdone), .REQ_ERR(rerr), .REQ_TIMEOUT(rto),
        .M_AXI_INIT_AXI_TXN(init), .M_AXI_TARGET_BASE(base),
        .M_AXI_TXN_DONE(done), .M_AXI_ERROR(error), .BUSY(busy), .TXN_COUNT(cnt)
    );

    internoc_ni_txn_scheduler #(.NUM_REQ(4), .ADDR_W(32), .TIMEOUT_CYCLES(16)) dut_wd (
        .ACLK(tb_ACLK), .ARESET(wd_areset), .REQ(wd_req), .REQ_ADDR(req_addr),
        .REQ_GNT(wd_gnt), .REQ_DONE(wd_rdone), .REQ_ERR(wd_rerr), .REQ_TIMEOUT(wd_rto),
        .M_AXI_INIT_AXI_TXN(wd_init), .M_AXI_TARGET_BASE(wd_base),
        .M_AXI_TXN_DONE(wd_done), .M_AXI_ERROR(wd_error), .BUSY(wd_busy), .TXN_COUNT(wd_cnt)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1; wd_areset = 1'b1;
        repeat (5) tick();
        checks++; if (gnt !== 4'b0 || rdone !== 4'b0 || rerr !== 4'b0 || rto !== 1'b0) begin
            $display("FAIL reset_req_outs gnt=%b done=%b err=%b to=%b exp all 0", gnt, rdone, rerr, rto); fails++; end
        checks++; if (init !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_init_busy init=%b busy=%b exp 0 0", init, busy); fails++; end
        checks++; if (base !== 32'h0 || cnt !== 16'h0) begin
            $display("FAIL reset_base_cnt base=%h cnt=%0d exp 0 0", base, cnt); fails++; end
        checks++; if (wd_busy !== 1'b0 || wd_gnt !== 4'b0) begin
            $display("FAIL reset_wd busy=%b gnt=%b exp 0 0", wd_busy, wd_gnt); fails++; end
        areset = 1'b0; wd_areset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int init_pulses = 0;
        req = 4'b0001;
        tick();
        checks++; if (gnt !== 4'b0001 || init !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL single_grant gnt=%b init=%b busy=%b exp 0001 1 1", gnt, init, busy); fails++; end
        checks++; if (base !== 32'h4000_0000) begin
            $display("FAIL single_base got=%h exp=40000000", base); fails++; end
        req = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (init === 1'b1) init_pulses++;
        end
        checks++; if (init_pulses != 0 || gnt !== 4'b0001) begin
            $display("FAIL single_hold extra_init=%0d gnt=%b exp 0 0001", init_pulses, gnt); fails++; end
        done = 1'b1;
        tick();
        checks++; if (rdone !== 4'b0001 || rerr !== 4'b0000 || rto !== 1'b0 || gnt !== 4'b0000) begin
            $display("FAIL single_done done=%b err=%b to=%b gnt=%b exp 0001 0000 0 0000", rdone, rerr, rto, gnt); fails++; end
        done = 1'b0;
        tick();
        checks++; if (rdone !== 4'b0000 || busy !== 1'b0 || cnt !== 16'd1) begin
            $display("FAIL single_after done=%b busy=%b cnt=%0d exp 0000 0 1", rdone, busy, cnt); fails++; end
        tick();
        checks++; if (base !== 32'h4000_0000) begin
            $display("FAIL single_base_hold got=%h exp=40000000", base); fails++; end
    endtask

    task automatic test_round_robin();
        int low_run = 0;
        logic [3:0]  exp_gnt;
        logic [31:0] exp_base;
        areset = 1'b1; tick(); areset = 1'b0;
        req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            exp_gnt  = 4'b0001 << (t % 4);
            exp_base = 32'h4000_0000 + 32'(t % 4) * 32'h0100_0000;
            tick();
            checks++; if (gnt !== exp_gnt || init !== 1'b1 || base !== exp_base) begin
                $display("FAIL rr_grant t=%0d gnt=%b init=%b base=%h exp %b 1 %h", t, gnt, init, base, exp_gnt, exp_base); fails++; end
            if (t > 0) begin
                checks++; if (low_run < 3) begin
                    $display("FAIL rr_init_spacing t=%0d low=%0d exp>=3", t, low_run); fails++; end
            end
            low_run = 0;
            for (int w = 0; w < 3; w++) begin
                tick();
                if (init === 1'b0) low_run++;
                if (!$onehot(gnt)) begin
                    $display("FAIL rr_onehot t=%0d gnt=%b", t, gnt); fails++;
                end
            end
            done = 1'b1;
            tick();
            if (init === 1'b0) low_run++;
            checks++; if (rdone !== exp_gnt) begin
                $display("FAIL rr_done t=%0d got=%b exp=%b", t, rdone, exp_gnt); fails++; end
            done = 1'b0;
            tick();
            if (init === 1'b0) low_run++;
        end
        req = 4'b0000;
        checks++; if (cnt !== 16'd8 || busy !== 1'b0) begin
            $display("FAIL rr_count cnt=%0d busy=%b exp 8 0", cnt, busy); fails++; end
    endtask

    task automatic test_error();
        req = 4'b0100;
        tick();
        checks++; if (gnt !== 4'b0100 || base !== 32'h4200_0000) begin
            $display("FAIL err_grant gnt=%b base=%h exp 0100 42000000", gnt, base); fails++; end
        req = 4'b0000;
        tick(); tick();
        done = 1'b1; error = 1'b1;
        tick();
        checks++; if (rdone !== 4'b0100 || rerr !== 4'b0100 || rto !== 1'b0) begin
            $display("FAIL err_resp done=%b err=%b to=%b exp 0100 0100 0", rdone, rerr, rto); fails++; end
        done = 1'b0; error = 1'b0;
        tick();
        checks++; if (rerr !== 4'b0000 || cnt !== 16'd9) begin
            $display("FAIL err_clear err=%b cnt=%0d exp 0000 9", rerr, cnt); fails++; end
    endtask

    task automatic test_stale_done();
        int early = 0;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick(); tick();
        done = 1'b1;
        tick();
        checks++; if (rdone !== 4'b0010) begin
            $display("FAIL stale_first got=%b exp=0010", rdone); fails++; end
        tick();
        req = 4'b1000;
        tick();
        checks++; if (gnt !== 4'b1000 || init !== 1'b1) begin
            $display("FAIL stale_grant gnt=%b init=%b exp 1000 1", gnt, init); fails++; end
        tick();
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rdone !== 4'b0000 || gnt !== 4'b1000) early++;
        end
        checks++; if (early != 0) begin
            $display("FAIL stale_ignored early_cycles=%0d exp 0", early); fails++; end
        done = 1'b0;
        tick();
        checks++; if (rdone !== 4'b0000 || busy !== 1'b1) begin
            $display("FAIL stale_fall done=%b busy=%b exp 0000 1", rdone, busy); fails++; end
        done = 1'b1;
        tick();
        checks++; if (rdone !== 4'b1000 || rerr !== 4'b0000) begin
            $display("FAIL stale_complete done=%b err=%b exp 1000 0000", rdone, rerr); fails++; end
        done = 1'b0;
        tick();
        checks++; if (cnt !== 16'd11 || busy !== 1'b0) begin
            $display("FAIL stale_count cnt=%0d busy=%b exp 11 0", cnt, busy); fails++; end
    endtask

    task automatic test_watchdog();
        int early = 0;
        wd_req = 4'b0001;
        tick();
        wd_req = 4'b0000;
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            if (wd_rdone !== 4'b0000) early++;
        end
        checks++; if (early != 0) begin
            $display("FAIL wd_early early_cycles=%0d exp 0", early); fails++; end
        tick();
        checks++; if (wd_rdone !== 4'b0001 || wd_rerr !== 4'b0001 || wd_rto !== 1'b1) begin
            $display("FAIL wd_fire done=%b err=%b to=%b exp 0001 0001 1", wd_rdone, wd_rerr, wd_rto); fails++; end
        tick();
        checks++; if (wd_rto !== 1'b0 || wd_busy !== 1'b0 || wd_cnt !== 16'd1) begin
            $display("FAIL wd_after to=%b busy=%b cnt=%0d exp 0 0 1", wd_rto, wd_busy, wd_cnt); fails++; end
        wd_req = 4'b0010;
        tick();
        checks++; if (wd_gnt !== 4'b0010) begin
            $display("FAIL wd_next_grant got=%b exp=0010", wd_gnt); fails++; end
        wd_req = 4'b0000;
        tick(); tick();
        wd_done = 1'b1;
        tick();
        checks++; if (wd_rdone !== 4'b0010 || wd_rto !== 1'b0) begin
            $display("FAIL wd_next_done done=%b to=%b exp 0010 0", wd_rdone, wd_rto); fails++; end
        wd_done = 1'b0;
        tick();
        // DONE edge lands exactly on the expiry cycle: completion must win.
        wd_req = 4'b0100;
        tick();
        wd_req = 4'b0000;
        tick();
        repeat (15) tick();
        wd_done = 1'b1;
        tick();
        checks++; if (wd_rdone !== 4'b0100 || wd_rerr !== 4'b0000 || wd_rto !== 1'b0) begin
            $display("FAIL wd_tie done=%b err=%b to=%b exp 0100 0000 0", wd_rdone, wd_rerr, wd_rto); fails++; end
        wd_done = 1'b0;
        tick();
        checks++; if (wd_cnt !== 16'd3) begin
            $display("FAIL wd_count got=%0d exp=3", wd_cnt); fails++; end
    endtask

    task automatic test_reset_mid_wait();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick(); tick();
        checks++; if (busy !== 1'b1 || gnt !== 4'b0100) begin
            $display("FAIL rst_pre busy=%b gnt=%b exp 1 0100", busy, gnt); fails++; end
        areset = 1'b1;
        done = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0 || rdone !== 4'b0 || rerr !== 4'b0 || rto !== 1'b0 || init !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL rst_outs gnt=%b done=%b err=%b to=%b init=%b busy=%b exp all 0", gnt, rdone, rerr, rto, init, busy); fails++; end
        checks++; if (base !== 32'h0 || cnt !== 16'h0) begin
            $display("FAIL rst_base_cnt base=%h cnt=%0d exp 0 0", base, cnt); fails++; end
        areset = 1'b0;
        done = 1'b0;
        tick();
        checks++; if (rdone !== 4'b0000) begin
            $display("FAIL rst_no_done got=%b exp=0000", rdone); fails++; end
        req = 4'b1111;
        tick();
        checks++; if (gnt !== 4'b0001) begin
            $display("FAIL rst_first_grant got=%b exp=0001", gnt); fails++; end
        req = 4'b0000;
        tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    initial begin
        areset = 1'b1; wd_areset = 1'b1;
        req = '0; wd_req = '0;
        done = 1'b0; error = 1'b0; wd_done = 1'b0; wd_error = 1'b0;
        req_addr = {32'h4300_0000, 32'h4200_0000, 32'h4100_0000, 32'h4000_0000};
        test_reset();
        test_single();
        test_round_robin();
        test_error();
        test_stale_done();
        test_watchdog();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
